decode_writeback: RTL
=====================

# decode_writeback

Y86-64 decode/writeback stage, directly downstream of fetch. Accepts decoded instruction fields (icode, ifun, rA, rB, valC), selects source and destination register IDs, reads operands valA/valB from a 15-entry 64-bit register file, and presents them registered to execute. The same block owns the register file write port, where the writeback of valE/valM from later stages lands. A two-state machine stops instruction intake after halt or an invalid icode.

## Interface
- REG_W, 64, register and data width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch fields valid
- in_ready  output  1  stage can accept
- icode, ifun, rA, rB  input  4 each  fetched fields
- valC  input  REG_W  fetched constant
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts bundle
- icode_o, ifun_o  output  4 each  passed through
- valC_o, valA, valB  output  REG_W  operands
- srcA, srcB, dstE, dstM  output  4 each  register IDs, 4'hF = none
- stat  output  2  0 AOK, 1 HLT, 2 INS
- w_dstE, w_dstM  input  4 each  writeback targets, 4'hF = none
- w_valE, w_valM  input  REG_W  writeback data

## Operation
- Register file: r0..r14, r4 = %rsp. ID 4'hF reads 0 and is never written.
- Source/destination selection (per icode):
  - srcA = rA for 2, 4, 6, A; 4 for 9, B; else F.
  - srcB = rB for 4, 5, 6; 4 for 8, 9, A, B; else F.
  - dstE = rB for 2, 3, 6; 4 for 8, 9, A, B; else F. cmov gating by cnd is done downstream.
  - dstM = rA for 5, B; else F.
- Writeback: every rising edge, in any state, write w_valE to w_dstE and w_valM to w_dstM when the ID is not F. If w_dstE == w_dstM, w_valM wins.
- FSM states:
  - RUN → HALT when an accepted icode is 0 or greater than B.
  - HALT is held until reset.
- in_ready = (state == RUN) && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the output register captures all output fields and sets out_valid = 1.
- stat on accept: HLT for icode 0, INS for icode > B, otherwise AOK. For INS, all four register IDs are F and valA = valB = 0.
- out_valid clears on out_ready when there is no simultaneous accept. Outputs hold stable while out_valid && !out_ready.
- In HALT, writeback continues and a pending bundle still drains.

## Timing
- Reset (asynchronous):
  - All registers = 0, state = RUN.
  - out_valid = 0, stat = 0.
  - All ID outputs = 4'hF; valA, valB, valC_o, icode_o, ifun_o = 0.
  - in_ready = 1 once rst_n is high.
- Latency: 1 cycle. Fields accepted at edge N appear on the outputs after edge N with out_valid = 1.
- Operand read uses register contents before edge N's writeback, unless bypass is compiled in (see Configuration).
- Throughput: 1 instruction per cycle while out_ready = 1.
- Reset asserted mid-operation clears the pending bundle and the register file immediately.

## Configuration
- DECODE_WB_BYPASS_EN defined: if a same-edge writeback targets srcA/srcB at accept, the captured valA/valB take the written data, with w_valM priority over w_valE.
- DECODE_WB_BYPASS_EN undefined: the captured value is the old register contents.

## Test plan
- Reset, then accept rrmovq (icode 2, rA=3, rB=7) → next cycle srcA=3, srcB=F, dstE=7, dstM=F, valA=0, stat=0.
- Writeback w_dstE=3, w_valE=0x1234; next cycle OPq (icode 6) rA=3, rB=3 → valA=valB=0x1234, dstE=3.
- w_dstE=w_dstM=4, w_valE=0xAA, w_valM=0xBB; then popq (icode B, rA=0) → srcA=srcB=4, valA=0xBB, dstM=0, dstE=4.
- Accept halt (icode 0) → stat=1, in_ready=0 permanently. A writeback still lands, checked after reset-free readback via the drained bundle. rst_n pulse → in_ready=1.
- out_ready held 0 for 3 cycles with in_valid=1 → outputs stable, exactly one accept. Release → next instruction follows in 1 cycle.
- Same-edge w_dstE=5, w_valE=0x99 while accepting rmmovq rA=5 → valA=0x99 with DECODE_WB_BYPASS_EN, otherwise the old value. icode 0xC → stat=2, all IDs F.

Source files
------------

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 decode/writeback stage.
//
// Decodes fetched fields into source/destination register IDs, reads valA/valB
// from a 15-entry register file (r0..r14, r4 = %rsp, ID 4'hF = none, reads 0),
// and presents the decoded bundle registered to execute using a valid/ready
// handshake. The register file write port takes writeback of valE/valM from
// later stages every cycle. After accepting halt (icode 0) or an invalid icode
// (> 4'hB) the stage stops taking instructions until reset.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         fetch handshake
//   icode, ifun, rA, rB, valC   fetched fields
//   out_valid / out_ready       execute handshake
//   icode_o, ifun_o, valC_o     passed-through fields
//   valA, valB                  operands
//   srcA, srcB, dstE, dstM      register IDs, 4'hF = none
//   stat                        0 AOK, 1 HLT, 2 INS
//   w_dstE, w_valE, w_dstM, w_valM  writeback port (w_valM wins on same ID)
//
// Build option: DECODE_WB_BYPASS_EN forwards a same-edge writeback into the
// captured valA/valB (valM over valE). Undefined: old register contents.

module decode_writeback #(
    parameter int unsigned REG_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic [REG_W-1:0] valC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       icode_o,
    output logic [3:0]       ifun_o,
    output logic [REG_W-1:0] valC_o,
    output logic [REG_W-1:0] valA,
    output logic [REG_W-1:0] valB,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [1:0]       stat,
    input  logic [3:0]       w_dstE,
    input  logic [3:0]       w_dstM,
    input  logic [REG_W-1:0] w_valE,
    input  logic [REG_W-1:0] w_valM
);

    localparam logic [3:0] NoReg = 4'hF;
    localparam logic [3:0] Rsp   = 4'h4;

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatHlt = 2'd1;
    localparam logic [1:0] StatIns = 2'd2;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e state_q, state_d;

    logic [REG_W-1:0] rf_q [0:14];

    logic             out_valid_q;
    logic [3:0]       icode_q, ifun_q, src_a_q, src_b_q, dst_e_q, dst_m_q;
    logic [REG_W-1:0] valc_q, val_a_q, val_b_q;
    logic [1:0]       stat_q;

    logic [3:0]       src_a, src_b, dst_e, dst_m;
    logic [REG_W-1:0] val_a, val_b;
    logic [1:0]       stat_d;
    logic             accept;
    logic             is_hlt, is_ins;

    assign is_hlt = (icode == 4'h0);
    assign is_ins = (icode > 4'hB);

    // ID selection; halt, nop, jXX and invalid icodes fall to the default (all none).
    always_comb begin
        src_a = NoReg;
        src_b = NoReg;
        dst_e = NoReg;
        dst_m = NoReg;
        case (icode)
            4'h2: begin src_a = rA;  dst_e = rB; end
            4'h3: begin dst_e = rB; end
            4'h4: begin src_a = rA;  src_b = rB; end
            4'h5: begin src_b = rB;  dst_m = rA; end
            4'h6: begin src_a = rA;  src_b = rB;  dst_e = rB; end
            4'h8: begin src_b = Rsp; dst_e = Rsp; end
            4'h9: begin src_a = Rsp; src_b = Rsp; dst_e = Rsp; end
            4'hA: begin src_a = rA;  src_b = Rsp; dst_e = Rsp; end
            4'hB: begin src_a = Rsp; src_b = Rsp; dst_e = Rsp; dst_m = rA; end
            default: ;
        endcase
    end

    always_comb begin
        val_a = (src_a == NoReg) ? '0 : rf_q[src_a];
        val_b = (src_b == NoReg) ? '0 : rf_q[src_b];
`ifdef DECODE_WB_BYPASS_EN
        if (src_a != NoReg) begin
            if (w_dstM == src_a)      val_a = w_valM;
            else if (w_dstE == src_a) val_a = w_valE;
        end
        if (src_b != NoReg) begin
            if (w_dstM == src_b)      val_b = w_valM;
            else if (w_dstE == src_b) val_b = w_valE;
        end
`endif
    end

    always_comb begin
        stat_d = StatAok;
        if (is_hlt)      stat_d = StatHlt;
        else if (is_ins) stat_d = StatIns;
    end

    assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (accept && (is_hlt || is_ins)) state_d = StHalt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StRun;
        else        state_q <= state_d;
    end

    // Write port is independent of the FSM; the valM write is issued last so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rf_q[i] <= '0;
        end else begin
            if (w_dstE != NoReg) rf_q[w_dstE] <= w_valE;
            if (w_dstM != NoReg) rf_q[w_dstM] <= w_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            icode_q     <= '0;
            ifun_q      <= '0;
            valc_q      <= '0;
            val_a_q     <= '0;
            val_b_q     <= '0;
            src_a_q     <= NoReg;
            src_b_q     <= NoReg;
            dst_e_q     <= NoReg;
            dst_m_q     <= NoReg;
            stat_q      <= StatAok;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            icode_q     <= icode;
            ifun_q      <= ifun;
            valc_q      <= valC;
            val_a_q     <= val_a;
            val_b_q     <= val_b;
            src_a_q     <= src_a;
            src_b_q     <= src_b;
            dst_e_q     <= dst_e;
            dst_m_q     <= dst_m;
            stat_q      <= stat_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign icode_o   = icode_q;
    assign ifun_o    = ifun_q;
    assign valC_o    = valc_q;
    assign valA      = val_a_q;
    assign valB      = val_b_q;
    assign srcA      = src_a_q;
    assign srcB      = src_b_q;
    assign dstE      = dst_e_q;
    assign dstM      = dst_m_q;
    assign stat      = stat_q;

endmodule
